// File: rtl/boot_sequencer_pkg.sv
// Shared CPU boot package: bus width defaults and the boot sequencer state encoding.
package boot_sequencer_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        HALT   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } bootState_t;

endpackage : boot_sequencer_pkg

// File: rtl/boot_sequencer_counter.sv
// boot_counter: load-address and remaining-byte counters for the program loader.
// The address wraps naturally at 2^ADDR_W; the byte count only ever steps down.
import boot_sequencer_pkg::*;

module boot_counter #(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              Clk,
    input  logic              RstN,
    input  logic              Load,
    input  logic [ADDR_W-1:0] StartAdr,
    input  logic [ADDR_W-1:0] LenIn,
    input  logic              Step,
    output logic [ADDR_W-1:0] AdrCnt,
    output logic [ADDR_W-1:0] RemCnt
);

    // Latch the load window on start, then advance one byte per accepted handshake.
    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            AdrCnt <= '0;
            RemCnt <= '0;
        end else if (Load) begin
            AdrCnt <= StartAdr;
            RemCnt <= LenIn;
        end else if (Step) begin
            AdrCnt <= AdrCnt + ADDR_W'(1);
            RemCnt <= RemCnt - ADDR_W'(1);
        end
    end

endmodule : boot_counter

// File: rtl/boot_sequencer.sv
// boot_sequencer: loads a program image from a byte stream into memory, then
// releases the CPU. Memory bus ownership is decided purely by the current state:
// the loader owns it in LOAD, the CPU in RUN, nobody in HALT/SETTLE.
import boot_sequencer_pkg::*;

module boot_sequencer #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              Clk,
    input  logic              RstN,
    input  logic              LoadReq,
    input  logic              HaltReq,
    input  logic [ADDR_W-1:0] StartAdr,
    input  logic [ADDR_W-1:0] LenIn,
    input  logic [DATA_W-1:0] RxData,
    input  logic              RxValid,
    output logic              RxReady,
    input  logic              CpuLdMem,
    input  logic              CpuWrtMem,
    input  logic [ADDR_W-1:0] CpuAdr,
    input  logic [DATA_W-1:0] CpuDataOut,
    output logic              MemLd,
    output logic              MemWrt,
    output logic [ADDR_W-1:0] MemAdr,
    output logic [DATA_W-1:0] MemDataOut,
    output logic              CPUEn,
    output logic              Busy,
    output logic              Done
);

    bootState_t        state;
    bootState_t        nextState;
    logic              loadStart;
    logic              handshake;
    logic [ADDR_W-1:0] adrCnt;
    logic [ADDR_W-1:0] remCnt;

    boot_counter #(
        .ADDR_W (ADDR_W)
    ) uCounter (
        .Clk      (Clk),
        .RstN     (RstN),
        .Load     (loadStart),
        .StartAdr (StartAdr),
        .LenIn    (LenIn),
        .Step     (handshake),
        .AdrCnt   (adrCnt),
        .RemCnt   (remCnt)
    );

    // Next-state selection and state-owned bus/handshake outputs; HaltReq wins everywhere.
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        nextState  = state;
        loadStart  = 1'b0;
        handshake  = 1'b0;
        RxReady    = 1'b0;
        MemLd      = 1'b0;
        MemWrt     = 1'b0;
        MemAdr     = '0;
        MemDataOut = '0;
        Busy       = 1'b0;
        case (state)
            HALT: begin
                if (LoadReq && !HaltReq) begin
                    if (LenIn != '0) begin
                        loadStart = 1'b1;
                        nextState = LOAD;
                    end else begin
                        nextState = SETTLE;
                    end
                end
            end
            LOAD: begin
                Busy       = 1'b1;
                RxReady    = !HaltReq;
                handshake  = RxValid && !HaltReq;
                MemWrt     = handshake;
                MemAdr     = adrCnt;
                MemDataOut = RxData;
                if (HaltReq) begin
                    nextState = HALT;
                end else if (handshake && (remCnt == ADDR_W'(1))) begin
                    nextState = SETTLE;
                end
            end
            SETTLE: begin
                Busy      = 1'b1;
                nextState = HaltReq ? HALT : RUN;
            end
            RUN: begin
                MemLd      = CpuLdMem;
                MemWrt     = CpuWrtMem;
                MemAdr     = CpuAdr;
                MemDataOut = CpuDataOut;
                if (HaltReq) begin
                    nextState = HALT;
                end
            end
            default: nextState = HALT;
        endcase
    end

    // State register plus CPU enable and RUN-entry pulse, both derived from next state.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state <= HALT;
            CPUEn <= 1'b0;
            Done  <= 1'b0;
        end else begin
            state <= nextState;
            CPUEn <= (nextState == RUN);
            Done  <= (nextState == RUN) && (state != RUN);
        end
    end

endmodule : boot_sequencer

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer: a per-cycle vector table for the load/run
// flows plus hand-written sequences for asynchronous reset in LOAD and RUN.
module tb_boot_sequencer;
    import boot_sequencer_pkg::*;

    localparam int AW = 16;
    localparam int DW = 8;

    logic          Clk;
    logic          RstN;
    logic          LoadReq;
    logic          HaltReq;
    logic [AW-1:0] StartAdr;
    logic [AW-1:0] LenIn;
    logic [DW-1:0] RxData;
    logic          RxValid;
    logic          RxReady;
    logic          CpuLdMem;
    logic          CpuWrtMem;
    logic [AW-1:0] CpuAdr;
    logic [DW-1:0] CpuDataOut;
    logic          MemLd;
    logic          MemWrt;
    logic [AW-1:0] MemAdr;
    logic [DW-1:0] MemDataOut;
    logic          CPUEn;
    logic          Busy;
    logic          Done;

    boot_sequencer #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .Clk        (Clk),
        .RstN       (RstN),
        .LoadReq    (LoadReq),
        .HaltReq    (HaltReq),
        .StartAdr   (StartAdr),
        .LenIn      (LenIn),
        .RxData     (RxData),
        .RxValid    (RxValid),
        .RxReady    (RxReady),
        .CpuLdMem   (CpuLdMem),
        .CpuWrtMem  (CpuWrtMem),
        .CpuAdr     (CpuAdr),
        .CpuDataOut (CpuDataOut),
        .MemLd      (MemLd),
        .MemWrt     (MemWrt),
        .MemAdr     (MemAdr),
        .MemDataOut (MemDataOut),
        .CPUEn      (CPUEn),
        .Busy       (Busy),
        .Done       (Done)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct packed {
        logic          loadReq;
        logic          haltReq;
        logic [AW-1:0] startAdr;
        logic [AW-1:0] lenIn;
        logic [DW-1:0] rxData;
        logic          rxValid;
        logic          cpuLd;
        logic          cpuWrt;
        logic [AW-1:0] cpuAdr;
        logic [DW-1:0] cpuData;
    } inVec_t;

    typedef struct packed {
        logic          rxReady;
        logic          memLd;
        logic          memWrt;
        logic [AW-1:0] memAdr;
        logic [DW-1:0] memData;
        logic          cpuEn;
        logic          busy;
        logic          done;
    } outVec_t;

    typedef struct {
        inVec_t  in;
        outVec_t exp;
    } vector_t;

    vector_t vecs[$];
    int      total;
    int      bad;

    function automatic inVec_t vi(logic lr, logic hr, logic [AW-1:0] sa, logic [AW-1:0] len,
                                  logic [DW-1:0] rd, logic rv, logic cl, logic cw,
                                  logic [AW-1:0] ca, logic [DW-1:0] cd);
        inVec_t v;
        v.loadReq  = lr;
        v.haltReq  = hr;
        v.startAdr = sa;
        v.lenIn    = len;
        v.rxData   = rd;
        v.rxValid  = rv;
        v.cpuLd    = cl;
        v.cpuWrt   = cw;
        v.cpuAdr   = ca;
        v.cpuData  = cd;
        return v;
    endfunction

    function automatic outVec_t vo(logic rr, logic ml, logic mw, logic [AW-1:0] ma,
                                   logic [DW-1:0] md, logic ce, logic bz, logic dn);
        outVec_t o;
        o.rxReady = rr;
        o.memLd   = ml;
        o.memWrt  = mw;
        o.memAdr  = ma;
        o.memData = md;
        o.cpuEn   = ce;
        o.busy    = bz;
        o.done    = dn;
        return o;
    endfunction

    function automatic outVec_t sample();
        return vo(RxReady, MemLd, MemWrt, MemAdr, MemDataOut, CPUEn, Busy, Done);
    endfunction

    task automatic add(inVec_t i, outVec_t o);
        vector_t v;
        v.in  = i;
        v.exp = o;
        vecs.push_back(v);
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic applyIn(inVec_t v);
        LoadReq    = v.loadReq;
        HaltReq    = v.haltReq;
        StartAdr   = v.startAdr;
        LenIn      = v.lenIn;
        RxData     = v.rxData;
        RxValid    = v.rxValid;
        CpuLdMem   = v.cpuLd;
        CpuWrtMem  = v.cpuWrt;
        CpuAdr     = v.cpuAdr;
        CpuDataOut = v.cpuData;
    endtask

    // Apply one cycle of inputs just after the edge, compare mid-cycle, advance one edge.
    task automatic runVec(int idx, vector_t v);
        applyIn(v.in);
        #3;
        check($sformatf("vec%0d", idx), 64'(sample()), 64'(v.exp));
        @(posedge Clk);
        #1;
    endtask

    task automatic tick(int n);
        for (int k = 0; k < n; k++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    initial begin
        inVec_t  idle;
        outVec_t zero;
        outVec_t settle;
        outVec_t runFirst;
        total    = 0;
        bad      = 0;
        idle     = vi(0, 0, 16'h0, 16'd0, 8'h00, 0, 0, 0, 16'h0, 8'h00);
        zero     = vo(0, 0, 0, 16'h0, 8'h00, 0, 0, 0);
        settle   = vo(0, 0, 0, 16'h0, 8'h00, 0, 1, 0);
        runFirst = vo(0, 0, 0, 16'h0, 8'h00, 1, 0, 1);

        // Basic load of three bytes from 0x0000, then CPU pass-through in RUN.
        add(idle, zero);
        add(vi(1, 0, 16'h0000, 16'd3, 8'h00, 0, 0, 0, 16'h0, 8'h00), zero);
        add(vi(0, 0, 16'h0, 16'd0, 8'hA1, 1, 0, 0, 16'h0, 8'h00), vo(1, 0, 1, 16'h0000, 8'hA1, 0, 1, 0));
        add(vi(0, 0, 16'h0, 16'd0, 8'hB2, 1, 0, 0, 16'h0, 8'h00), vo(1, 0, 1, 16'h0001, 8'hB2, 0, 1, 0));
        add(vi(0, 0, 16'h0, 16'd0, 8'hC3, 1, 0, 0, 16'h0, 8'h00), vo(1, 0, 1, 16'h0002, 8'hC3, 0, 1, 0));
        add(idle, settle);
        add(idle, runFirst);
        add(vi(1, 0, 16'h0, 16'd5, 8'h00, 0, 0, 1, 16'h1234, 8'h5A), vo(0, 0, 1, 16'h1234, 8'h5A, 1, 0, 0));
        add(vi(0, 1, 16'h0, 16'd0, 8'h00, 0, 1, 0, 16'h4321, 8'h77), vo(0, 1, 0, 16'h4321, 8'h77, 1, 0, 0));
        add(idle, zero);
        // Address wrap from 0xFFFE.
        add(vi(1, 0, 16'hFFFE, 16'd3, 8'h00, 0, 0, 0, 16'h0, 8'h00), zero);
        add(vi(0, 0, 16'h0, 16'd0, 8'h11, 1, 0, 0, 16'h0, 8'h00), vo(1, 0, 1, 16'hFFFE, 8'h11, 0, 1, 0));
        add(vi(0, 0, 16'h0, 16'd0, 8'h22, 1, 0, 0, 16'h0, 8'h00), vo(1, 0, 1, 16'hFFFF, 8'h22, 0, 1, 0));
        add(vi(0, 0, 16'h0, 16'd0, 8'h33, 1, 0, 0, 16'h0, 8'h00), vo(1, 0, 1, 16'h0000, 8'h33, 0, 1, 0));
        add(idle, settle);
        add(idle, runFirst);
        add(vi(0, 1, 16'h0, 16'd0, 8'h00, 0, 0, 0, 16'h0, 8'h00), vo(0, 0, 0, 16'h0, 8'h00, 1, 0, 0));
        add(idle, zero);
        // Zero-length load goes straight to SETTLE.
        add(vi(1, 0, 16'h4000, 16'd0, 8'h00, 0, 0, 0, 16'h0, 8'h00), zero);
        add(idle, settle);
        add(idle, runFirst);
        add(vi(0, 1, 16'h0, 16'd0, 8'h00, 0, 0, 0, 16'h0, 8'h00), vo(0, 0, 0, 16'h0, 8'h00, 1, 0, 0));
        add(idle, zero);
        // Gapped stream: one valid, two idle, one valid.
        add(vi(1, 0, 16'h0100, 16'd2, 8'h00, 0, 0, 0, 16'h0, 8'h00), zero);
        add(vi(0, 0, 16'h0, 16'd0, 8'hD1, 1, 0, 0, 16'h0, 8'h00), vo(1, 0, 1, 16'h0100, 8'hD1, 0, 1, 0));
        add(idle, vo(1, 0, 0, 16'h0101, 8'h00, 0, 1, 0));
        add(idle, vo(1, 0, 0, 16'h0101, 8'h00, 0, 1, 0));
        add(vi(0, 0, 16'h0, 16'd0, 8'hD2, 1, 0, 0, 16'h0, 8'h00), vo(1, 0, 1, 16'h0101, 8'hD2, 0, 1, 0));
        add(idle, settle);
        add(idle, runFirst);
        add(vi(0, 1, 16'h0, 16'd0, 8'h00, 0, 0, 0, 16'h0, 8'h00), vo(0, 0, 0, 16'h0, 8'h00, 1, 0, 0));
        add(idle, zero);
        // Abort on the second byte of a four-byte load.
        add(vi(1, 0, 16'h0200, 16'd4, 8'h00, 0, 0, 0, 16'h0, 8'h00), zero);
        add(vi(0, 0, 16'h0, 16'd0, 8'hE1, 1, 0, 0, 16'h0, 8'h00), vo(1, 0, 1, 16'h0200, 8'hE1, 0, 1, 0));
        add(vi(0, 1, 16'h0, 16'd0, 8'hE2, 1, 0, 0, 16'h0, 8'h00), vo(0, 0, 0, 16'h0201, 8'hE2, 0, 1, 0));
        add(idle, zero);
        add(idle, zero);
        // LoadReq blocked by a simultaneous HaltReq.
        add(vi(1, 1, 16'h0000, 16'd3, 8'h00, 0, 0, 0, 16'h0, 8'h00), zero);
        add(idle, zero);

        // Reset state, checked before any clock edge is seen.
        applyIn(idle);
        RstN = 1'b0;
        #2;
        check("reset_outputs", 64'(sample()), 64'(zero));
        @(posedge Clk);
        #1;
        RstN = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            runVec(i, vecs[i]);
        end

        // Asynchronous reset in the middle of a load kills the write immediately.
        applyIn(vi(1, 0, 16'h0300, 16'd5, 8'h00, 0, 0, 0, 16'h0, 8'h00));
        tick(1);
        applyIn(vi(0, 0, 16'h0, 16'd0, 8'hAA, 1, 0, 0, 16'h0, 8'h00));
        #2;
        check("midload_write", {62'd0, RxReady, MemWrt}, 64'h3);
        RstN = 1'b0;
        #1;
        check("midload_reset", {61'd0, RxReady, MemWrt, Busy}, 64'h0);
        tick(1);
        RstN = 1'b1;
        applyIn(idle);
        tick(3);
        check("stay_halt", {61'd0, Busy, CPUEn, RxReady}, 64'h0);

        // CPU enable drops at once when reset hits during RUN.
        applyIn(vi(1, 0, 16'h0, 16'd0, 8'h00, 0, 0, 0, 16'h0, 8'h00));
        tick(1);
        applyIn(idle);
        tick(1);
        check("run_entry", {62'd0, CPUEn, Done}, 64'h3);
        tick(1);
        check("run_steady", {62'd0, CPUEn, Done}, 64'h2);
        #2;
        RstN = 1'b0;
        #1;
        check("run_reset", {62'd0, CPUEn, Done}, 64'h0);
        tick(1);
        RstN = 1'b1;
        tick(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_boot_sequencer
